// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared defaults and types for the memory port arbiter family.
//   DEF_NP/DEF_AW/DEF_DW : default port count, address width, data width
//   idx_width()          : port-index width, never below 1 bit
//   port_idx_t/rd_tag_t  : port index and in-flight read tag for DEF_NP ports
package mem_arb_pkg;

  localparam int DEF_NP = 3;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 128;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(DEF_NP);

  typedef logic [IDX_W-1:0] port_idx_t;

  typedef struct packed {
    logic      vld;
    port_idx_t idx;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant over NP requesters.
//   req     : request vector
//   en      : when low, no grant and pointer holds
//   ptr     : current round-robin pointer (search starts here)
//   gnt     : one-hot grant (or zero)
//   gnt_idx : index of the granted requester
//   ptr_nxt : pointer for the next cycle ((grant+1) mod NP, or ptr)
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NP = DEF_NP,
  localparam int IW = idx_width(NP)
) (
  input  logic [NP-1:0] req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [NP-1:0] gnt,
  output logic [IW-1:0] gnt_idx,
  output logic [IW-1:0] ptr_nxt
);

  int unsigned  idx;
  logic         found;
  logic [NP-1:0] bit_sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    ptr_nxt = ptr;
    idx     = 0;
    found   = 1'b0;
    bit_sel = '0;
    if (en) begin
      for (int unsigned i = 0; i < NP; i++) begin
        idx     = (int'(ptr) + i) % NP;
        bit_sel = NP'(1) << idx;
        if (!found && |(req & bit_sel)) begin
          found   = 1'b1;
          gnt     = bit_sel;
          gnt_idx = IW'(idx);
          ptr_nxt = IW'((idx + 1) % NP);
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges NP client request ports onto one memory port with
// round-robin arbitration, a registered issue stage and an in-order read
// return path of RD_LAT+2 cycles from handshake to rsp_valid.
//   clk/rstn                 : clock, asynchronous active-low reset
//   req_valid/ready/we/addr/wdata/wstrb : per-port request channel (ready comb)
//   mem_stall                : blocks all grants this cycle
//   rsp_valid/rsp_data       : one-hot read response pulse and its data
//   ren/raddr/rdata          : memory read port (rdata RD_LAT cycles after ren)
//   wen/waddr/wdata/wstrb    : memory write port
// Optional: define MEM_PORT_ARBITER_STATS_EN for per-port saturating
//   read/write grant counters on stat_rd_cnt/stat_wr_cnt.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NP     = DEF_NP,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NP-1:0]     req_valid,
  output logic [NP-1:0]     req_ready,
  input  logic [NP-1:0]     req_we,
  input  logic [NP*AW-1:0]  req_addr,
  input  logic [NP*DW-1:0]  req_wdata,
  input  logic [NP*DW/8-1:0] req_wstrb,
  input  logic              mem_stall,
  output logic [NP-1:0]     rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              ren,
  output logic [AW-1:0]     raddr,
  input  logic [DW-1:0]     rdata,
  output logic              wen,
  output logic [AW-1:0]     waddr,
  output logic [DW-1:0]     wdata,
  output logic [DW/8-1:0]   wstrb
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [NP*32-1:0]  stat_rd_cnt,
  output logic [NP*32-1:0]  stat_wr_cnt
`endif
);

  localparam int IW = idx_width(NP);
  localparam int SW = DW / 8;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } tag_t;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [NP-1:0] gnt;
  logic          any_hs, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [SW-1:0] sel_wstrb;

  logic          ren_q, ren_d, wen_q, wen_d;
  logic [AW-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [NP-1:0] rsp_valid_q, rsp_valid_d;
  tag_t          tag_q [RD_LAT+1];
  tag_t          tag_d [RD_LAT+1];

  rr_arbiter #(.NP(NP)) u_rr (
    .req     (req_valid),
    .en      (!mem_stall),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .ptr_nxt (rr_ptr_d)
  );

  // gnt only ever selects a valid requester, so it is the handshake itself.
  assign req_ready = gnt;
  assign any_hs    = |gnt;
  assign sel_we    = req_we[gnt_idx];
  assign sel_addr  = req_addr[gnt_idx*AW +: AW];
  assign sel_wdata = req_wdata[gnt_idx*DW +: DW];
  assign sel_wstrb = req_wstrb[gnt_idx*SW +: SW];

  always_comb begin
    ren_d   = any_hs && !sel_we;
    wen_d   = any_hs && sel_we;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if (ren_d) raddr_d = sel_addr;
    if (wen_d) begin
      waddr_d = sel_addr;
      wdata_d = sel_wdata;
      wstrb_d = sel_wstrb;
    end

    // Stage 0 lines up with ren; stage RD_LAT lines up with valid rdata.
    tag_d[0] = '{vld: ren_d, idx: gnt_idx};
    for (int unsigned i = 1; i <= RD_LAT; i++) tag_d[i] = tag_q[i-1];

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_q[RD_LAT].vld) begin
      rsp_valid_d = NP'(1) << tag_q[RD_LAT].idx;
      rsp_data_d  = rdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q    <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      ren_q       <= ren_d;
      wen_q       <= wen_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tag_q       <= tag_d;
    end
  end

  assign ren       = ren_q;
  assign wen       = wen_q;
  assign raddr     = raddr_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] rd_cnt_q [NP];
  logic [31:0] rd_cnt_d [NP];
  logic [31:0] wr_cnt_q [NP];
  logic [31:0] wr_cnt_d [NP];

  always_comb begin
    stat_rd_cnt = '0;
    stat_wr_cnt = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      rd_cnt_d[p] = rd_cnt_q[p];
      wr_cnt_d[p] = wr_cnt_q[p];
      if (gnt[p] && !req_we[p] && rd_cnt_q[p] != '1) rd_cnt_d[p] = rd_cnt_q[p] + 32'd1;
      if (gnt[p] &&  req_we[p] && wr_cnt_q[p] != '1) wr_cnt_d[p] = wr_cnt_q[p] + 32'd1;
      stat_rd_cnt[p*32 +: 32] = rd_cnt_q[p];
      stat_wr_cnt[p*32 +: 32] = wr_cnt_q[p];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned p = 0; p < NP; p++) begin
        rd_cnt_q[p] <= '0;
        wr_cnt_q[p] <= '0;
      end
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter (NP=3, RD_LAT=2).
// A scoreboard model schedules expected memory ops and responses per cycle
// from the arbitration rules; a byte-addressed memory answers reads with an
// address pattern unless written. Literal checks pin each scenario.
module tb_mem_port_arbiter;

  localparam int NP = 3, AW = 32, DW = 128, SW = DW / 8, RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NP-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic [NP*SW-1:0]  req_wstrb;
  logic              mem_stall, ren, wen;
  logic [DW-1:0]     rsp_data, rdata, wdata;
  logic [AW-1:0]     raddr, waddr;
  logic [SW-1:0]     wstrb;
`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [NP*32-1:0]  stat_rd_cnt, stat_wr_cnt;
`endif

  mem_port_arbiter #(.NP(NP), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .mem_stall(mem_stall), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .ren(ren), .raddr(raddr), .rdata(rdata),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
`ifdef MEM_PORT_ARBITER_STATS_EN
    , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [7:0]    mem [int unsigned];
  logic [DW-1:0] pipe [0:RD_LAT];
  assign rdata = pipe[RD_LAT];

  function automatic logic [DW-1:0] lookup(input logic [AW-1:0] a);
    logic [DW-1:0] pat, r;
    pat = {4{a}};
    for (int i = 0; i < SW; i++)
      r[8*i +: 8] = mem.exists(a + i) ? mem[a + i] : pat[8*i +: 8];
    return r;
  endfunction

  // ---------------- scoreboard model ----------------
  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } op_t;
  typedef struct packed {
    logic [NP-1:0] onehot;
    logic [DW-1:0] data;
  } rsp_t;

  op_t  sched_op  [int];
  rsp_t sched_rsp [int];
  int   rr;
  logic [AW-1:0] e_raddr, e_waddr;
  logic [DW-1:0] e_wdata, e_rspd;
  logic [SW-1:0] e_wstrb;
  int unsigned   m_rd [NP];
  int unsigned   m_wr [NP];

  logic [NP-1:0] log_ready [int];
  logic [NP-1:0] log_rspv  [int];
  logic [DW-1:0] log_rspd  [int];
  logic          log_ren   [int];
  logic          log_wen   [int];

  always @(negedge clk) begin
    op_t           o;
    rsp_t          r;
    logic [NP-1:0] e_rspv, e_ready;
    int            g, p;
    log_ready[cyc] = req_ready;
    log_rspv[cyc]  = rsp_valid;
    log_rspd[cyc]  = rsp_data;
    log_ren[cyc]   = ren;
    log_wen[cyc]   = wen;
    if (!rstn) begin
      rr = 0;
      sched_op.delete();
      sched_rsp.delete();
      e_raddr = '0; e_waddr = '0; e_wdata = '0; e_wstrb = '0; e_rspd = '0;
      for (int i = 0; i < NP; i++) begin m_rd[i] = 0; m_wr[i] = 0; end
      for (int i = 0; i <= RD_LAT; i++) pipe[i] = '0;
      chk("rst_ren", DW'(ren), '0);
      chk("rst_wen", DW'(wen), '0);
      chk("rst_rsp_valid", DW'(rsp_valid), '0);
      chk("rst_rsp_data", rsp_data, '0);
      chk("rst_raddr", DW'(raddr), '0);
      chk("rst_waddr", DW'(waddr), '0);
      chk("rst_wdata", wdata, '0);
      chk("rst_wstrb", DW'(wstrb), '0);
    end else begin
      // memory acts on this cycle's ports
      if (wen)
        for (int i = 0; i < SW; i++) if (wstrb[i]) mem[waddr + i] = wdata[8*i +: 8];
      for (int i = RD_LAT; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = ren ? lookup(raddr) : '0;

      // compare against what the model scheduled for this cycle
      o = sched_op.exists(cyc) ? sched_op[cyc] : '0;
      sched_op.delete(cyc);
      if (o.rd) e_raddr = o.addr;
      if (o.wr) begin e_waddr = o.addr; e_wdata = o.data; e_wstrb = o.strb; end
      chk("ren", DW'(ren), DW'(o.rd));
      chk("wen", DW'(wen), DW'(o.wr));
      chk("raddr", DW'(raddr), DW'(e_raddr));
      chk("waddr", DW'(waddr), DW'(e_waddr));
      chk("wdata", wdata, e_wdata);
      chk("wstrb", DW'(wstrb), DW'(e_wstrb));
      e_rspv = '0;
      if (sched_rsp.exists(cyc)) begin
        r = sched_rsp[cyc];
        sched_rsp.delete(cyc);
        e_rspv = r.onehot;
        e_rspd = r.data;
      end
      chk("rsp_valid", DW'(rsp_valid), DW'(e_rspv));
      chk("rsp_data", rsp_data, e_rspd);
`ifdef MEM_PORT_ARBITER_STATS_EN
      for (int i = 0; i < NP; i++) begin
        chk("stat_rd", DW'(stat_rd_cnt[i*32 +: 32]), DW'(m_rd[i]));
        chk("stat_wr", DW'(stat_wr_cnt[i*32 +: 32]), DW'(m_wr[i]));
      end
`endif

      // arbitration decision for this cycle
      g = -1;
      if (!mem_stall)
        for (int k = 0; k < NP; k++) begin
          p = (rr + k) % NP;
          if (g < 0 && req_valid[p]) g = p;
        end
      e_ready = (g >= 0) ? NP'(1) << g : '0;
      chk("req_ready", DW'(req_ready), DW'(e_ready));
      if (g >= 0) begin
        rr     = (g + 1) % NP;
        o.rd   = !req_we[g];
        o.wr   = req_we[g];
        o.addr = req_addr[g*AW +: AW];
        o.data = req_wdata[g*DW +: DW];
        o.strb = req_wstrb[g*SW +: SW];
        sched_op[cyc + 1] = o;
        if (o.rd) begin
          sched_rsp[cyc + RD_LAT + 2] = '{onehot: NP'(1) << g, data: lookup(o.addr)};
          if (m_rd[g] != 32'hFFFF_FFFF) m_rd[g]++;
        end else if (m_wr[g] != 32'hFFFF_FFFF) m_wr[g]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
    mem_stall = 1'b0;
  endtask

  task automatic set_req(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[p]          = 1'b1;
    req_we[p]             = we;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
    req_wstrb[p*SW +: SW] = s;
  endtask

  initial begin
    logic [NP-1:0] exp_rot [6];
    logic [DW-1:0] v;
    int t;
    exp_rot = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    idle();
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) step();
    rstn = 1'b1;
    step();

    // all three ports read continuously
    t = cyc;
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 32'h1000 + 32'(p) * 32'h10, '0, '0);
    repeat (6) step();
    idle();
    repeat (RD_LAT + 5) step();
    for (int k = 0; k < 6; k++) begin
      chk("rot_grant", DW'(log_ready[t + k]), DW'(exp_rot[k]));
      chk("rot_rsp", DW'(log_rspv[t + 4 + k]), DW'(exp_rot[k]));
    end

    // single port 0, two back-to-back reads
    t = cyc;
    set_req(0, 1'b0, 32'h100, '0, '0);
    step();
    set_req(0, 1'b0, 32'h110, '0, '0);
    step();
    idle();
    repeat (RD_LAT + 5) step();
    chk("p0_ren_a", DW'(log_ren[t + 1]), DW'(1'b1));
    chk("p0_ren_b", DW'(log_ren[t + 2]), DW'(1'b1));
    chk("p0_rsp_a", DW'(log_rspv[t + 4]), DW'(3'b001));
    chk("p0_rsp_b", DW'(log_rspv[t + 5]), DW'(3'b001));
    chk("p0_data_a", log_rspd[t + 4], {4{32'h0000_0100}});
    chk("p0_data_b", log_rspd[t + 5], {4{32'h0000_0110}});

    // port 1 write then port 2 read of the same address
    t = cyc;
    set_req(1, 1'b1, 32'h40, 128'hDEAD_BEEF, 16'h000F);
    step();
    idle();
    set_req(2, 1'b0, 32'h40, '0, '0);
    step();
    idle();
    repeat (RD_LAT + 5) step();
    chk("raw_wen", DW'(log_wen[t + 1]), DW'(1'b1));
    chk("raw_ren", DW'(log_ren[t + 2]), DW'(1'b1));
    chk("raw_rspv", DW'(log_rspv[t + 5]), DW'(3'b100));
    v = log_rspd[t + 5];
    chk("raw_data", v, {32'h40, 32'h40, 32'h40, 32'hDEAD_BEEF});

    // stall 5 cycles with a read in flight
    t = cyc;
    set_req(0, 1'b0, 32'h200, '0, '0);
    step();
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 32'h2000 + 32'(p) * 32'h10, '0, '0);
    mem_stall = 1'b1;
    repeat (5) step();
    mem_stall = 1'b0;
    step();
    idle();
    repeat (RD_LAT + 5) step();
    for (int k = 1; k <= 5; k++) chk("stall_ready", DW'(log_ready[t + k]), '0);
    for (int k = 2; k <= 6; k++) chk("stall_ren", DW'(log_ren[t + k] | log_wen[t + k]), '0);
    chk("stall_rsp", DW'(log_rspv[t + 4]), DW'(3'b001));
    chk("stall_resume", DW'(log_ready[t + 6]), DW'(3'b010));

    // reset with two reads in flight
    t = cyc;
    set_req(0, 1'b0, 32'h300, '0, '0);
    step();
    set_req(0, 1'b0, 32'h310, '0, '0);
    step();
    idle();
    rstn = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    repeat (6) step();
    chk("rst_imm_ren", DW'(log_ren[t + 2]), '0);
    for (int k = 2; k < 10; k++) chk("rst_no_stale", DW'(log_rspv[t + k]), '0);

    // 7 reads on port 0 then 3 writes on port 2
    for (int k = 0; k < 7; k++) begin
      set_req(0, 1'b0, 32'h500 + 32'(k) * 32'h10, '0, '0);
      step();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      set_req(2, 1'b1, 32'h600 + 32'(k) * 32'h10, 128'(k), 16'hFFFF);
      step();
    end
    idle();
    repeat (RD_LAT + 4) step();
`ifdef MEM_PORT_ARBITER_STATS_EN
    chk("cnt_rd0", DW'(stat_rd_cnt[31:0]), DW'(32'd7));
    chk("cnt_wr2", DW'(stat_wr_cnt[95:64]), DW'(32'd3));
    chk("cnt_rd_rest", DW'(stat_rd_cnt[95:32]), '0);
    chk("cnt_wr_rest", DW'(stat_wr_cnt[63:0]), '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Merges NP independent client request ports onto one shared byte-addressed memory port: ren/raddr/rdata for reads, wen/waddr/wdata/wstrb for writes.
- Generalises the single-master RAM hookup to multiple masters, using round-robin arbitration and a configurable memory read latency.
- Routes read data back to the requesting port in issue order.
- Sits between the accelerator's DMA masters (weights, activations, output) and the DPI/RAM model or an on-chip SRAM.

Parameters:
- NP, 3: number of client ports, ≥1.
- AW, 32: address width.
- DW, 128: data width; must be a multiple of 8.
- RD_LAT, 0: memory read latency in cycles. rdata is valid RD_LAT cycles after the cycle ren is high; 0 means combinational read in the same cycle.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NP  per-port request valid.
- req_ready  out  NP  per-port grant, combinational.
- req_we  in  NP  1 = write, 0 = read.
- req_addr  in  NP*AW  per-port byte address.
- req_wdata  in  NP*DW  per-port write data.
- req_wstrb  in  NP*DW/8  per-port byte enables.
- mem_stall  in  1  when high, no grant is issued this cycle.
- rsp_valid  out  NP  one-hot read-response pulse.
- rsp_data  out  DW  read data for the port flagged in rsp_valid.
- ren  out  1  memory read enable.
- raddr  out  AW  memory read address.
- rdata  in  DW  memory read data.
- wen  out  1  memory write enable.
- waddr  out  AW  memory write address.
- wdata  out  DW  memory write data.
- wstrb  out  DW/8  memory write byte strobe.

Behaviour:
- Reset values: ren, wen, rsp_valid, rr_ptr = 0; raddr, waddr, wdata, wstrb, rsp_data = 0. Every in-flight read tag is cleared.
- Reset mid-operation: pending responses are dropped and never delivered.
- Arbitration, per cycle, when mem_stall = 0:
  - Grant the first port p with req_valid[p] = 1, searching from rr_ptr upward with wrap modulo NP.
  - req_ready is one-hot (or zero); the handshake is req_valid & req_ready.
  - After a grant to port p, rr_ptr becomes (p+1) mod NP.
  - With no valid request, rr_ptr is unchanged and no grant is issued.
- When mem_stall = 1: req_ready = 0 and rr_ptr holds. The read return pipeline keeps advancing regardless of mem_stall.
- Issue stage (registered): a handshake in cycle t drives exactly one of ren or wen high in cycle t+1, with the granted port's addr/wdata/wstrb.
  - Only one memory op per cycle; ren and wen are never both high.
  - Without a handshake in cycle t, ren = wen = 0 in t+1. Address and data outputs hold their last value.
- Read tag pipeline:
  - A read issue pushes the port index into a shift register of depth RD_LAT+1, each stage with a valid bit.
  - rdata is sampled in cycle t+1+RD_LAT.
  - rsp_valid[p] = 1 and rsp_data = rdata are registered in cycle t+2+RD_LAT.
  - Total read latency from handshake to response is RD_LAT+2 cycles.
  - rsp_valid is a single-cycle pulse; rsp_data holds between responses.
- Responses are not backpressured; clients must accept them.
- Back-to-back reads sustain one response per cycle.
- Ordering: responses return in grant order.
- A write granted before a read to the same address is presented to memory first. Read-after-write correctness is then the memory's responsibility.
- Writes produce no response.
- NP = 1: the arbiter degenerates to pass-through; rr_ptr stays 0.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- When defined, adds output ports stat_rd_cnt (NP*32) and stat_wr_cnt (NP*32).
  - Per-port counters of granted reads and writes.
  - Each counter increments on its handshake and saturates at 2^32-1.
  - Counters reset to 0.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - localparam defaults for NP, AW, DW;
  - typedef port_idx_t (logic [$clog2(NP)-1:0], min width 1);
  - typedef rd_tag_t as a struct {logic vld; port_idx_t idx}.
- Sub-module rr_arbiter: NP-bit request vector plus enable in; one-hot grant and rr_ptr update out. Reused by later blocks.
- The read tag pipeline stays inline.

Test Plan:
- Single port 0, reads to 0x100 then 0x110, RD_LAT=2, memory returns addr-pattern data:
  - ren high in cycles 1 and 2 after the handshakes;
  - rsp_valid = 3'b001 in cycles 4 and 5 with matching data.
- All 3 ports issue continuous reads:
  - grants rotate 0,1,2,0,1,2;
  - responses are one-hot in the same order;
  - no gaps at 1 response per cycle.
- Port 1 writes 0xDEAD_BEEF, strobe 0x000F, to 0x40; port 2 then reads 0x40:
  - wen precedes ren;
  - rsp_data[31:0] = 0xDEADBEEF on rsp_valid = 3'b100.
- mem_stall held high 5 cycles with all ports valid:
  - req_ready = 0, ren = wen = 0, rr_ptr unchanged;
  - in-flight reads still return.
- Reset asserted with 2 reads in flight:
  - every output is 0 immediately;
  - after release, no stale rsp_valid appears.
- With MEM_PORT_ARBITER_STATS_EN: 7 reads on port 0 and 3 writes on port 2:
  - stat_rd_cnt[0] = 7, stat_wr_cnt[2] = 3, all other counters 0.
